decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage for the RV32I/RV64I integer core.
- Decodes the full OP (0x33) and OP-IMM (0x13) instruction groups into register numbers, an XLEN immediate, an ALU opcode and control flags.
- Sits between the fetch stage and the register-read/ALU stage.
- Uses a valid/ready handshake with backpressure and flush, flags illegal encodings, and keeps a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets the immediate width and the shift-amount width.
- ADDR_W, 32, instruction address width.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills the held entry and any same-cycle capture.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- inst  in  32  instruction word.
- inst_addr  in  ADDR_W  instruction address.
- out_valid  out  1  decoded entry is valid.
- out_ready  in  1  downstream accepts the entry.
- out_inst_addr  out  ADDR_W  registered copy of inst_addr.
- rs1_num, rs2_num, rd_num  out  5 each  register numbers.
- imm  out  XLEN  immediate operand.
- alu_control  out  4  ALU opcode.
- is_unsigned  out  1  set for unsigned compare.
- use_imm  out  1  operand B comes from imm.
- reg_write  out  1  instruction writes rd.
- illegal  out  1  unsupported or malformed encoding.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, every decoded output=0, alu_control=4'b1111, illegal_count=0. in_ready is 1 in the cycle after reset.
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An instruction is captured when in_valid && in_ready && !flush.
  - out_valid rises in the next cycle (latency 1).
  - When out_valid && !out_ready, all outputs hold stable.
  - When out_valid && out_ready and there is no new capture, out_valid falls next cycle.
  - Back-to-back throughput is one instruction per cycle.
- Flush: out_valid=0 next cycle; no capture that cycle even if in_valid && in_ready; illegal_count unchanged. Priority order is rst > flush > capture.
- Every decoded field is computed fresh for every captured instruction. No field keeps its value from an earlier instruction; in particular, is_unsigned=0 unless the instruction is SLTU or SLTIU.
- ALU codes: AND 0000, SLL 0001, ADD 0010, OR 0011, SUB 0100, SLT 0101, XOR 0110, SRL 0111, SRA 1000, illegal 1111.
- OP (0x33):
  - rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7]; imm=0; use_imm=0; reg_write=1.
  - funct7=0x00 with funct3 0..7 selects ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND. SLTU uses the SLT code with is_unsigned=1.
  - funct7=0x20 is legal only with funct3=0 (SUB) or funct3=5 (SRA).
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (0x13):
  - rs1=inst[19:15], rs2=0, rd=inst[11:7], use_imm=1, reg_write=1.
  - imm = sign-extension of inst[31:20] to XLEN.
  - funct3 selects ADDI, SLTI, SLTIU (is_unsigned=1), XORI, ORI, ANDI.
  - Shifts (funct3 1 and 5): shamt width SW = log2(XLEN), so 5 bits for RV32 and 6 for RV64. imm = zero-extended inst[20+SW-1:20].
  - Bits inst[31:20+SW] must be zero, except inst[30]=1 is allowed for SRAI. Anything else is illegal.
- Any other opcode is illegal.
- Illegal entry outputs: rs1=rs2=rd=0, imm=0, use_imm=0, reg_write=0, alu_control=1111, illegal=1, out_valid=1. The entry is still passed downstream so the trap logic can use it.
- illegal_count: increments by 1 on each capture of an illegal instruction and saturates at all-ones. Flushed or uncaptured instructions are not counted.
- A write to x0 (rd=0) is legal; reg_write=1 is still reported and suppression is downstream's job.

Test Plan:
1. Reset, then inst=0x002081B3 (add x3,x1,x2) at inst_addr=0x100, out_ready=1. Required: next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu=0010, use_imm=0, out_inst_addr=0x100.
2. inst=0xFFF00093 (addi x1,x0,-1), XLEN=32. Required: imm=0xFFFFFFFF, alu=0010, use_imm=1, is_unsigned=0. Then send sltiu; required is_unsigned=1. Then addi again; required is_unsigned back to 0.
3. inst=0x40315113 (srai x2,x2,3). Required: alu=1000, imm=3, illegal=0. Then 0x02315113 (bit 25 set). Required: illegal=1 at XLEN=32, but legal SRLI with imm=35 at XLEN=64.
4. Backpressure: send sub 0x407302B3 with out_ready=0 for 3 cycles. Required: outputs stable at alu=0100, rd=5, in_ready=0. On out_ready=1 the next queued instruction follows with no bubble.
5. Flush: assert flush with out_valid=1 and a same-cycle in_valid. Required: out_valid=0 next cycle, nothing captured.
6. Stream 0x00000000 five times. Required: illegal=1, alu=1111 each time and illegal_count=5. With CNT_W=2 the counter saturates at 3. Then rst=1 mid-stream; required: out_valid=0 and illegal_count=0 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage for the OP and OP-IMM groups: one registered entry
// with a valid/ready handshake, flush, and a saturating illegal-instruction counter.
module decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_inst_addr,
  output logic [4:0]        rs1_num,
  output logic [4:0]        rs2_num,
  output logic [4:0]        rd_num,
  output logic [XLEN-1:0]   imm,
  output logic [3:0]        alu_control,
  output logic              is_unsigned,
  output logic              use_imm,
  output logic              reg_write,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  // Bits above the shift amount must be zero for a legal immediate shift.
  localparam logic [31:0] SHIFT_HI_MASK = ~((32'd1 << (20 + SW)) - 32'd1);
  localparam logic [31:0] SRAI_BIT      = 32'h4000_0000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            capture;

  logic            legal;
  logic [3:0]      alu_sel;
  logic            uns_sel;
  logic            imm_sel;
  logic [XLEN-1:0] imm_val;

  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [4:0]      d_rd;
  logic [XLEN-1:0] d_imm;
  logic [3:0]      d_alu;
  logic            d_uns;
  logic            d_use_imm;
  logic            d_reg_write;
  logic            d_illegal;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Classify the instruction and pick ALU op, immediate and legality.
  always_comb begin
    legal   = 1'b0;
    alu_sel = ALU_ILL;
    uns_sel = 1'b0;
    imm_sel = 1'b0;
    imm_val = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00) begin
          legal = 1'b1;
          case (funct3)
            3'd0:    alu_sel = ALU_ADD;
            3'd1:    alu_sel = ALU_SLL;
            3'd2:    alu_sel = ALU_SLT;
            3'd3:    begin alu_sel = ALU_SLT; uns_sel = 1'b1; end
            3'd4:    alu_sel = ALU_XOR;
            3'd5:    alu_sel = ALU_SRL;
            3'd6:    alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          legal   = 1'b1;
          alu_sel = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          legal   = 1'b1;
          alu_sel = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        legal   = 1'b1;
        imm_sel = 1'b1;
        imm_val = XLEN'($signed(inst[31:20]));
        case (funct3)
          3'd0: alu_sel = ALU_ADD;
          3'd1: begin
            alu_sel = ALU_SLL;
            imm_val = XLEN'(inst[20 +: SW]);
            legal   = (inst & SHIFT_HI_MASK) == 32'd0;
          end
          3'd2: alu_sel = ALU_SLT;
          3'd3: begin alu_sel = ALU_SLT; uns_sel = 1'b1; end
          3'd4: alu_sel = ALU_XOR;
          3'd5: begin
            alu_sel = inst[30] ? ALU_SRA : ALU_SRL;
            imm_val = XLEN'(inst[20 +: SW]);
            legal   = (inst & SHIFT_HI_MASK & ~SRAI_BIT) == 32'd0;
          end
          3'd6:    alu_sel = ALU_OR;
          default: alu_sel = ALU_AND;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to the fixed trap entry.
  always_comb begin
    d_rs1       = '0;
    d_rs2       = '0;
    d_rd        = '0;
    d_imm       = '0;
    d_alu       = ALU_ILL;
    d_uns       = 1'b0;
    d_use_imm   = 1'b0;
    d_reg_write = 1'b0;
    d_illegal   = 1'b1;
    if (legal) begin
      d_rs1       = inst[19:15];
      d_rs2       = imm_sel ? 5'd0 : inst[24:20];
      d_rd        = inst[11:7];
      d_imm       = imm_val;
      d_alu       = alu_sel;
      d_uns       = uns_sel;
      d_use_imm   = imm_sel;
      d_reg_write = 1'b1;
      d_illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_inst_addr <= '0;
      rs1_num       <= '0;
      rs2_num       <= '0;
      rd_num        <= '0;
      imm           <= '0;
      alu_control   <= ALU_ILL;
      is_unsigned   <= 1'b0;
      use_imm       <= 1'b0;
      reg_write     <= 1'b0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      out_inst_addr <= inst_addr;
      rs1_num       <= d_rs1;
      rs2_num       <= d_rs2;
      rd_num        <= d_rd;
      imm           <= d_imm;
      alu_control   <= d_alu;
      is_unsigned   <= d_uns;
      use_imm       <= d_use_imm;
      reg_write     <= d_reg_write;
      illegal       <= d_illegal;
      if (d_illegal && (illegal_count != '1)) begin
        illegal_count <= illegal_count + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 32-bit and a 64-bit (2-bit counter) instance share
// the same stimulus and are compared every cycle against a behavioural model.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_uns, a_ui, a_rw, a_ill;
  logic [31:0] a_addr;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [31:0] a_imm;
  logic [3:0]  a_alu;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_uns, b_ui, b_rw, b_ill;
  logic [31:0] b_addr;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [63:0] b_imm;
  logic [3:0]  b_alu;
  logic [1:0]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic        uns, ui, rw, ill;
    longint      cnt;
  } mdl_t;

  mdl_t ma, mb;

  decode_stage #(.XLEN(32), .ADDR_W(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .inst(inst), .inst_addr(inst_addr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_inst_addr(a_addr), .rs1_num(a_rs1), .rs2_num(a_rs2), .rd_num(a_rd), .imm(a_imm),
    .alu_control(a_alu), .is_unsigned(a_uns), .use_imm(a_ui), .reg_write(a_rw),
    .illegal(a_ill), .illegal_count(a_cnt)
  );

  decode_stage #(.XLEN(64), .ADDR_W(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .inst(inst), .inst_addr(inst_addr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_inst_addr(b_addr), .rs1_num(b_rs1), .rs2_num(b_rs2), .rd_num(b_rd), .imm(b_imm),
    .alu_control(b_alu), .is_unsigned(b_uns), .use_imm(b_ui), .reg_write(b_rw),
    .illegal(b_ill), .illegal_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA rules.
  function automatic mdl_t decode_ref(input mdl_t m, input logic [31:0] ins, input int xlen);
    mdl_t        r = m;
    logic [3:0]  tab [8] = '{4'h2, 4'h1, 4'h5, 4'h5, 4'h6, 4'h7, 4'h3, 4'h0};
    int          op  = int'(ins[6:0]);
    int          f3  = int'(ins[14:12]);
    int          f7  = int'(ins[31:25]);
    int          sw  = (xlen == 64) ? 6 : 5;
    longint      hi  = longint'(ins) >> (20 + sw);
    longint      sh  = (longint'(ins) >> 20) & ((longint'(1) << sw) - 1);
    logic [63:0] ext = {{52{ins[31]}}, ins[31:20]};
    bit          ok  = 1'b0;
    logic [3:0]  alu = 4'hF;
    logic [63:0] iv  = 64'd0;
    if (xlen == 32) ext = ext & 64'hFFFF_FFFF;
    if (op == 'h33) begin
      if (f7 == 0) begin ok = 1; alu = tab[f3]; end
      else if (f7 == 'h20 && f3 == 0) begin ok = 1; alu = 4'h4; end
      else if (f7 == 'h20 && f3 == 5) begin ok = 1; alu = 4'h8; end
    end else if (op == 'h13) begin
      ok = 1; alu = tab[f3]; iv = ext;
      if (f3 == 1) begin
        iv = 64'(sh); ok = (hi == 0);
      end else if (f3 == 5) begin
        iv = 64'(sh);
        ok = ((hi & ~(longint'(1) << (10 - sw))) == 0);
        alu = ins[30] ? 4'h8 : 4'h7;
      end
    end
    r.ill = !ok;
    r.rs1 = ok ? ins[19:15] : 5'd0;
    r.rs2 = (ok && op == 'h33) ? ins[24:20] : 5'd0;
    r.rd  = ok ? ins[11:7] : 5'd0;
    r.imm = ok ? iv : 64'd0;
    r.alu = ok ? alu : 4'hF;
    r.uns = ok && (f3 == 3);
    r.ui  = ok && (op == 'h13);
    r.rw  = ok;
    return r;
  endfunction

  function automatic mdl_t step_ref(input mdl_t m, input int xlen, input longint cmax);
    mdl_t r = m;
    if (rst) begin
      r = '{v: 0, addr: 0, rs1: 0, rs2: 0, rd: 0, imm: 0, alu: 4'hF,
            uns: 0, ui: 0, rw: 0, ill: 0, cnt: 0};
    end else if (flush) begin
      r.v = 0;
    end else if (in_valid && (!m.v || out_ready)) begin
      r = decode_ref(m, inst, xlen);
      r.v = 1;
      r.addr = inst_addr;
      if (r.ill && r.cnt < cmax) r.cnt = r.cnt + 1;
    end else if (out_ready) begin
      r.v = 0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    ma = step_ref(ma, 32, 65535);
    mb = step_ref(mb, 64, 3);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("a_out_valid", 64'(a_out_valid), 64'(ma.v));
      chk("a_in_ready", 64'(a_in_ready), 64'(!ma.v || out_ready));
      chk("a_count", 64'(a_cnt), 64'(ma.cnt));
      chk("b_out_valid", 64'(b_out_valid), 64'(mb.v));
      chk("b_in_ready", 64'(b_in_ready), 64'(!mb.v || out_ready));
      chk("b_count", 64'(b_cnt), 64'(mb.cnt));
      if (ma.v) begin
        chk("a_entry", {a_addr, a_rs1, a_rs2, a_rd, a_alu, a_uns, a_ui, a_rw, a_ill},
            {ma.addr, ma.rs1, ma.rs2, ma.rd, ma.alu, ma.uns, ma.ui, ma.rw, ma.ill});
        chk("a_imm", 64'(a_imm), ma.imm);
      end
      if (mb.v) begin
        chk("b_entry", {b_addr, b_rs1, b_rs2, b_rd, b_alu, b_uns, b_ui, b_rw, b_ill},
            {mb.addr, mb.rs1, mb.rs2, mb.rd, mb.alu, mb.uns, mb.ui, mb.rw, mb.ill});
        chk("b_imm", b_imm, mb.imm);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] i,
                     input logic [31:0] a, input logic o);
    rst = r; flush = f; in_valid = v; inst = i; inst_addr = a; out_ready = o;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    int          k = $urandom_range(0, 9);
    int          s = $urandom_range(0, 5);
    if (k <= 3) begin
      w[6:0] = 7'h33;
      w[31:25] = (s < 3) ? 7'h00 : (s < 5) ? 7'h20 : w[31:25];
    end else if (k <= 7) begin
      w[6:0] = 7'h13;
      if (s < 4) begin
        w[31:26] = 6'd0;
        if (s == 0) w[30] = 1'b1;
        if (s == 1) w[25] = 1'b0;
      end
    end else if (k == 9) begin
      w = 32'd0;
    end
    return w;
  endfunction

  initial begin
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    started = 1'b1;
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_alu", 64'(a_alu), 64'hF);
    chk("rst_imm", 64'(a_imm), 64'd0);
    chk("rst_count", 64'(a_cnt), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);

    cyc(0, 0, 1, 32'h002081B3, 32'h100, 1);
    chk("add_fields", {a_out_valid, a_rs1, a_rs2, a_rd, a_alu, a_ui},
        {1'b1, 5'd1, 5'd2, 5'd3, 4'b0010, 1'b0});
    chk("add_addr", 64'(a_addr), 64'h100);

    cyc(0, 0, 1, 32'hFFF00093, 32'h104, 1);
    chk("addi_imm32", 64'(a_imm), 64'hFFFF_FFFF);
    chk("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_ctl", {a_alu, a_ui, a_uns}, {4'b0010, 1'b1, 1'b0});
    cyc(0, 0, 1, 32'hFFF03093, 32'h108, 1);
    chk("sltiu_ctl", {a_alu, a_uns}, {4'b0101, 1'b1});
    cyc(0, 0, 1, 32'hFFF00093, 32'h10C, 1);
    chk("addi_uns_clear", 64'(a_uns), 64'd0);

    cyc(0, 0, 1, 32'h40315113, 32'h110, 1);
    chk("srai", {a_alu, a_ill}, {4'b1000, 1'b0});
    chk("srai_imm", 64'(a_imm), 64'd3);
    cyc(0, 0, 1, 32'h02315113, 32'h114, 1);
    chk("srli_b25_rv32", {a_ill, a_alu}, {1'b1, 4'hF});
    chk("srli_b25_rv64", {b_ill, b_alu}, {1'b0, 4'b0111});
    chk("srli_b25_imm64", b_imm, 64'd35);
    chk("count_rv32_one", 64'(a_cnt), 64'd1);

    cyc(0, 0, 1, 32'h407302B3, 32'h300, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 32'h002081B3, 32'h200, 0);
      chk("bp_hold", {a_out_valid, a_alu, a_rd, a_in_ready}, {1'b1, 4'b0100, 5'd5, 1'b0});
      chk("bp_addr", 64'(a_addr), 64'h300);
    end
    cyc(0, 0, 1, 32'h002081B3, 32'h200, 1);
    chk("bp_release", {a_out_valid, a_alu}, {1'b1, 4'b0010});
    chk("bp_release_addr", 64'(a_addr), 64'h200);

    cyc(0, 1, 1, 32'hFFF00093, 32'h400, 1);
    chk("flush_valid", 64'(a_out_valid), 64'd0);
    cyc(0, 0, 0, 32'hFFF00093, 32'h404, 1);
    chk("flush_no_capture", 64'(a_out_valid), 64'd0);

    cyc(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 32'd0, 32'h500 + 32'(4 * k), 1);
      chk("zero_illegal", {a_out_valid, a_ill, a_alu, a_rw}, {1'b1, 1'b1, 4'hF, 1'b0});
    end
    chk("count_five", 64'(a_cnt), 64'd5);
    chk("count_sat", 64'(b_cnt), 64'd3);
    cyc(1, 0, 1, 32'd0, 32'h600, 1);
    chk("midrst", {a_out_valid, a_cnt, b_out_valid, b_cnt}, {1'b0, 16'd0, 1'b0, 2'd0});

    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0, rand_inst(), $urandom,
          $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
